tcdm_bank_rr_arbiter: RTL
=========================

Name: tcdm_bank_rr_arbiter

Overview:
- Shares one single-port, 1-cycle-latency TCDM bank (tc_sram-style) between NbPorts requesters.
- Uses per-cycle round-robin arbitration with a same-cycle grant, and routes each response back to the winning requester one cycle after the grant.
- Counts arbitration conflicts for the cluster performance counters.
- Sits between the logarithmic interconnect branch and a bank instance inside the TCDM bank wrapper.

Parameters:
- NbPorts, 4, number of requesters sharing the bank (>=2)
- BankSize, 256, words in the bank (power of 2)
- DataWidth, 32, data width in bits
- AddrWidth, 32, requester byte-address width
- BeWidth, DataWidth/8, byte-enable width
- CntWidth, 16, width of the conflict counter

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous reset, active low
- req_i  input  NbPorts  per-requester request
- gnt_o  output  NbPorts  per-requester grant (one-hot or zero)
- add_i  input  NbPorts x AddrWidth  byte address
- wen_i  input  NbPorts  1=read, 0=write
- data_i  input  NbPorts x DataWidth  write data
- be_i  input  NbPorts x BeWidth  byte enables
- r_valid_o  output  NbPorts  response valid, one cycle after grant
- r_data_o  output  DataWidth  read data, shared by all requesters
- bank_req_o  output  1  bank request
- bank_we_o  output  1  bank write enable, active high
- bank_addr_o  output  $clog2(BankSize)  bank word address
- bank_wdata_o  output  DataWidth  bank write data
- bank_be_o  output  BeWidth  bank byte enables
- bank_rdata_i  input  DataWidth  bank read data, valid one cycle after bank_req_o
- cnt_clr_i  input  1  synchronous clear of the conflict counter
- conflicts_o  output  CntWidth  saturating conflict count
- init_done_o  output  1  bank usable

Behaviour:
- Reset values: gnt_o=0, r_valid_o=0, bank_req_o=0, conflicts_o=0, rr pointer=0, response-index register=0.
- Arbitration (combinational):
  - The winner is the first requester with req_i=1, searching from the pointer upward and wrapping at NbPorts-1 -> 0.
  - gnt_o[winner]=1; all other grant bits are 0.
  - The grant never depends on the bank; the bank is always ready.
- Bank drive:
  - bank_req_o = |req_i (while in RUN).
  - bank_we_o = ~wen_i[winner].
  - bank_addr_o = add_i[winner][$clog2(BankSize)+1:2].
  - bank_wdata_o and bank_be_o are taken from the winner.
- Pointer: on any grant, the pointer becomes (winner+1) mod NbPorts. With no request, it holds.
- Response:
  - A registered one-hot copy of gnt_o drives r_valid_o in the next cycle, for both reads and writes.
  - r_data_o = bank_rdata_i at all times; it is meaningful only where r_valid_o=1.
  - Back-to-back grants produce back-to-back responses with no bubbles.
- Conflict counter:
  - In each cycle where popcount(req_i)>=2 in RUN, the counter increments by 1 and saturates at all-ones.
  - cnt_clr_i has priority over the increment (clear wins in the same cycle).
- Requesters must hold req_i and payload stable until granted; a losing requester is served within NbPorts-1 cycles.
- Reset mid-operation: any pending r_valid is dropped and the pointer returns to 0.

Optional Feature:
- Macro: TCDM_BANK_ARB_INIT_EN.
- With the macro defined:
  - An INIT/RUN FSM starts in INIT after reset, with init_done_o=0.
  - INIT writes 0 to word addresses 0..BankSize-1, one per cycle (bank_req_o=1, bank_we_o=1, bank_be_o=all ones, bank_wdata_o=0).
  - During INIT, gnt_o=0, r_valid_o=0, and the counter is frozen.
  - After address BankSize-1 is written, the FSM moves to RUN the next cycle, init_done_o=1, and stays in RUN until reset.
- Without the macro: no FSM, and init_done_o=1 from reset.

Decomposition:
- Package tcdm_arb_pkg holds:
  - port index typedef idx_t (logic [$clog2(NbPorts)-1:0])
  - FSM state enum {INIT, RUN}
  - helper function rr_pick(req, ptr) -> idx_t
- One natural sub-module, tcdm_rr_picker: combinational round-robin priority selector with a pointer input, reusable by other interconnect arbiters.

Test Plan:
- NbPorts=4, only port 2 reads address 0x10 -> gnt_o=4'b0100 in the same cycle; bank_addr_o=4; r_valid_o=4'b0100 next cycle with r_data_o equal to the bank word.
- All 4 ports request continuously for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3; conflicts_o=8; r_valid_o follows the grant with one-cycle lag.
- Port 3 writes 0xDEADBEEF with be=4'b0011 to 0x20, then port 3 reads 0x20 -> read returns the low half updated to 0xBEEF and the upper half unchanged (bank simulation initialised to all ones gives 0xFFFFBEEF).
- Run conflicts for 2^16+5 cycles -> conflicts_o saturates at 0xFFFF; assert cnt_clr_i together with a conflict -> 0 next cycle.
- Assert rst_ni low in the cycle after a grant -> r_valid_o=0 immediately, pointer=0, the next simultaneous request from all ports grants port 0.
- With TCDM_BANK_ARB_INIT_EN and BankSize=256 -> exactly 256 zero writes, gnt_o=0 throughout even with all req_i=1, init_done_o rises on cycle 256, and a read of word 255 returns 0.

Source files
------------

// File: rtl/tcdm_arb_pkg.sv
// Shared types for the TCDM bank round-robin arbiter: port index type,
// INIT/RUN state encoding and a reference round-robin pick helper sized
// for the default four-port configuration.
package tcdm_arb_pkg;

    localparam int unsigned DefNbPorts = 4;
    localparam int unsigned IdxWidth   = $clog2(DefNbPorts);

    typedef logic [IdxWidth-1:0] idx_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } arb_state_e;

    // First requester at or above ptr, wrapping at DefNbPorts-1 -> 0.
    // Returns 0 when nothing is requesting.
    function automatic idx_t rr_pick(input logic [DefNbPorts-1:0] req, input idx_t ptr);
        idx_t              pick;
        logic              found;
        logic [IdxWidth:0] cand;
        pick  = {IdxWidth{1'b0}};
        found = 1'b0;
        for (int i = 0; i < DefNbPorts; i++) begin
            cand = {1'b0, ptr} + (IdxWidth+1)'(i);
            if (cand >= (IdxWidth+1)'(DefNbPorts)) begin
                cand = cand - (IdxWidth+1)'(DefNbPorts);
            end else begin
                cand = cand;
            end
            if (!found && req[cand[IdxWidth-1:0]]) begin
                pick  = cand[IdxWidth-1:0];
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/tcdm_rr_picker.sv
// Combinational round-robin priority selector. Searches from ptr_i upward,
// wrapping at NbPorts-1 -> 0, and returns the first requester as a one-hot
// grant plus its index. Works for any NbPorts >= 2, power of two or not.
module tcdm_rr_picker #(
    parameter int unsigned NbPorts = 4,
    parameter int unsigned IdxW    = $clog2(NbPorts)
) (
    input  logic [NbPorts-1:0] req_i,
    input  logic [IdxW-1:0]    ptr_i,
    output logic [NbPorts-1:0] gnt_o,
    output logic [IdxW-1:0]    idx_o,
    output logic               valid_o
);

    localparam int unsigned CandW = IdxW + 1;

    logic [CandW-1:0] cand_s;

    // Rotating priority search; the first hit from the pointer wins.
    always_comb begin
        gnt_o   = {NbPorts{1'b0}};
        idx_o   = {IdxW{1'b0}};
        valid_o = 1'b0;
        cand_s  = {CandW{1'b0}};
        for (int i = 0; i < NbPorts; i++) begin
            cand_s = {1'b0, ptr_i} + CandW'(i);
            if (cand_s >= CandW'(NbPorts)) begin
                cand_s = cand_s - CandW'(NbPorts);
            end else begin
                cand_s = cand_s;
            end
            if (!valid_o && req_i[cand_s[IdxW-1:0]]) begin
                gnt_o[cand_s[IdxW-1:0]] = 1'b1;
                idx_o                   = cand_s[IdxW-1:0];
                valid_o                 = 1'b1;
            end else begin
                valid_o = valid_o;
            end
        end
    end

endmodule

// File: rtl/tcdm_bank_rr_arbiter.sv
// Shares one single-port, 1-cycle-latency TCDM bank between NbPorts
// requesters. Same-cycle round-robin grant, response valid one cycle after
// the grant, saturating arbitration-conflict counter.
// Optional macro TCDM_BANK_ARB_INIT_EN: after reset the bank is zero-filled
// (one word per cycle) before requesters are served; without it the bank is
// usable straight out of reset.
module tcdm_bank_rr_arbiter
    import tcdm_arb_pkg::*;
#(
    parameter int unsigned NbPorts   = 4,
    parameter int unsigned BankSize  = 256,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned BeWidth   = DataWidth / 8,
    parameter int unsigned CntWidth  = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NbPorts-1:0]             req_i,
    output logic [NbPorts-1:0]             gnt_o,
    input  logic [NbPorts*AddrWidth-1:0]   add_i,
    input  logic [NbPorts-1:0]             wen_i,
    input  logic [NbPorts*DataWidth-1:0]   data_i,
    input  logic [NbPorts*BeWidth-1:0]     be_i,
    output logic [NbPorts-1:0]             r_valid_o,
    output logic [DataWidth-1:0]           r_data_o,
    output logic                           bank_req_o,
    output logic                           bank_we_o,
    output logic [$clog2(BankSize)-1:0]    bank_addr_o,
    output logic [DataWidth-1:0]           bank_wdata_o,
    output logic [BeWidth-1:0]             bank_be_o,
    input  logic [DataWidth-1:0]           bank_rdata_i,
    input  logic                           cnt_clr_i,
    output logic [CntWidth-1:0]            conflicts_o,
    output logic                           init_done_o
);

    localparam int unsigned PortIdxW  = $clog2(NbPorts);
    localparam int unsigned BankAddrW = $clog2(BankSize);

    logic                 run_s;
    logic [BankAddrW-1:0] init_addr_s;

    logic [PortIdxW-1:0]  ptr_q, ptr_d;
    logic [PortIdxW-1:0]  win_idx_s;
    logic [NbPorts-1:0]   pick_gnt_s;
    logic                 pick_valid_s;
    logic [NbPorts-1:0]   gnt_s;
    logic [NbPorts-1:0]   r_valid_q, r_valid_d;
    logic                 multi_req_s;
    logic [CntWidth-1:0]  cnt_q, cnt_d;

    logic                 sel_wen_s;
    logic [BankAddrW-1:0] sel_addr_s;
    logic [DataWidth-1:0] sel_wdata_s;
    logic [BeWidth-1:0]   sel_be_s;

    // Only the word-address bits of add_i reach the bank.
    logic                 unused_addr_s;
    assign unused_addr_s = ^add_i;

`ifdef TCDM_BANK_ARB_INIT_EN
    arb_state_e           state_q, state_d;
    logic [BankAddrW-1:0] init_addr_q, init_addr_d;

    // INIT/RUN state and zero-fill address registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= INIT;
            init_addr_q <= {BankAddrW{1'b0}};
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
        end
    end

    // Walk every word once, then hand the bank to the requesters for good.
    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        case (state_q)
            INIT: begin
                if (init_addr_q == BankAddrW'(BankSize - 1)) begin
                    state_d     = RUN;
                    init_addr_d = {BankAddrW{1'b0}};
                end else begin
                    state_d     = INIT;
                    init_addr_d = init_addr_q + BankAddrW'(1);
                end
            end
            RUN: begin
                state_d     = RUN;
                init_addr_d = {BankAddrW{1'b0}};
            end
            default: begin
                state_d     = INIT;
                init_addr_d = {BankAddrW{1'b0}};
            end
        endcase
    end

    assign run_s       = (state_q == RUN);
    assign init_addr_s = init_addr_q;
`else
    assign run_s       = 1'b1;
    assign init_addr_s = {BankAddrW{1'b0}};
`endif

    tcdm_rr_picker #(
        .NbPorts (NbPorts),
        .IdxW    (PortIdxW)
    ) i_picker (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt_s),
        .idx_o   (win_idx_s),
        .valid_o (pick_valid_s)
    );

    // Two or more simultaneous requests: clearing the lowest set bit leaves something.
    assign multi_req_s = |(req_i & (req_i - NbPorts'(1)));

    assign gnt_s = run_s ? pick_gnt_s : {NbPorts{1'b0}};

    // Payload of the current winner.
    always_comb begin
        sel_wen_s   = 1'b1;
        sel_addr_s  = {BankAddrW{1'b0}};
        sel_wdata_s = {DataWidth{1'b0}};
        sel_be_s    = {BeWidth{1'b0}};
        for (int p = 0; p < NbPorts; p++) begin
            if (win_idx_s == PortIdxW'(p)) begin
                sel_wen_s   = wen_i[p];
                sel_addr_s  = add_i[p*AddrWidth+2 +: BankAddrW];
                sel_wdata_s = data_i[p*DataWidth +: DataWidth];
                sel_be_s    = be_i[p*BeWidth +: BeWidth];
            end else begin
                sel_wen_s = sel_wen_s;
            end
        end
    end

    // Bank port: zero-fill writes during INIT, the winner's access during RUN.
    always_comb begin
        if (!run_s) begin
            bank_req_o   = 1'b1;
            bank_we_o    = 1'b1;
            bank_addr_o  = init_addr_s;
            bank_wdata_o = {DataWidth{1'b0}};
            bank_be_o    = {BeWidth{1'b1}};
        end else begin
            bank_req_o   = pick_valid_s;
            bank_we_o    = ~sel_wen_s;
            bank_addr_o  = sel_addr_s;
            bank_wdata_o = sel_wdata_s;
            bank_be_o    = sel_be_s;
        end
    end

    // Pointer moves past the winner on every grant and holds otherwise.
    always_comb begin
        if (run_s && pick_valid_s) begin
            if (win_idx_s == PortIdxW'(NbPorts - 1)) begin
                ptr_d = {PortIdxW{1'b0}};
            end else begin
                ptr_d = win_idx_s + PortIdxW'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Response valid is the grant delayed by the bank's one-cycle latency.
    always_comb begin
        r_valid_d = gnt_s;
    end

    // Conflict counter: clear beats increment, saturates at all-ones.
    always_comb begin
        if (cnt_clr_i) begin
            cnt_d = {CntWidth{1'b0}};
        end else if (run_s && multi_req_s && (cnt_q != {CntWidth{1'b1}})) begin
            cnt_d = cnt_q + CntWidth'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q     <= {PortIdxW{1'b0}};
            r_valid_q <= {NbPorts{1'b0}};
            cnt_q     <= {CntWidth{1'b0}};
        end else begin
            ptr_q     <= ptr_d;
            r_valid_q <= r_valid_d;
            cnt_q     <= cnt_d;
        end
    end

    assign gnt_o       = gnt_s;
    assign r_valid_o   = r_valid_q;
    assign r_data_o    = bank_rdata_i;
    assign conflicts_o = cnt_q;
    assign init_done_o = run_s;

endmodule
